// File: rtl/spi_frame_unpack.sv
// spi_frame_unpack: takes 256-bit frames from an SPI slave, validates the header
// in word 0 and streams payload words 1..N out over a valid/ready handshake.
// Also keeps frame/error counters and returns a status snapshot frame to the slave.
//
// Parameters:
//   MAGIC        required header byte, frame bits [15:8]
// Ports:
//   CLK          clock, rising edge
//   RESET        asynchronous active-high reset
//   FRAME_IN     256-bit frame, word k = bits [16k+15:16k]
//   FRAME_WRITE  pulse: FRAME_IN valid
//   FRAME_READ   pulse: host read started, snapshot status and clear error counters
//   STATUS_OUT   status frame back to the SPI slave
//   WORD_OUT     payload word k
//   WORD_INDEX   index k (1..15) of WORD_OUT
//   WORD_VALID   WORD_OUT/WORD_INDEX valid
//   WORD_READY   downstream accepts the word
//   BUSY         frame in progress (state != IDLE)
//
// Build option: define SPI_FRAME_CHECKSUM_EN to reserve word 15 as an XOR
// checksum of words 0..14 (max payload 14 words); otherwise up to 15 words.

module spi_frame_unpack #(
  parameter logic [7:0] MAGIC = 8'hA5
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [255:0] FRAME_IN,
  input  logic         FRAME_WRITE,
  input  logic         FRAME_READ,
  output logic [255:0] STATUS_OUT,
  output logic [15:0]  WORD_OUT,
  output logic [3:0]   WORD_INDEX,
  output logic         WORD_VALID,
  input  logic         WORD_READY,
  output logic         BUSY
);

  localparam int unsigned FRAME_W = 256;
  localparam int unsigned WORD_W  = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SEND  = 2'd2
  } state_t;

  state_t              state;
  logic [FRAME_W-1:0]  buffer;
  logic [15:0]         frames_ok;
  logic [7:0]          frames_bad;
  logic [7:0]          overrun;

  logic [3:0]          n_c;
  logic                range_ok_c;
  logic                csum_ok_c;
  logic                hdr_ok_c;
  logic [3:0]          idx_nxt_c;
  logic                bad_evt_c;
  logic                ovr_evt_c;
  logic [7:0]          bad_base_c;
  logic [7:0]          ovr_base_c;
  logic [7:0]          bad_next_c;
  logic [7:0]          ovr_next_c;
  logic [FRAME_W-1:0]  status_c;

  assign n_c = buffer[7:4];

`ifdef SPI_FRAME_CHECKSUM_EN
  logic [WORD_W-1:0] csum_c;

  // XOR of words 0..14 must match word 15
  always_comb begin
    csum_c = '0;
    for (int i = 0; i < 15; i++) begin
      csum_c = csum_c ^ buffer[16*i +: WORD_W];
    end
  end

  assign csum_ok_c  = (csum_c == buffer[255:240]);
  assign range_ok_c = (n_c != 4'd0) && (n_c != 4'd15);
`else
  assign csum_ok_c  = 1'b1;
  assign range_ok_c = (n_c != 4'd0);
`endif

  assign hdr_ok_c  = (buffer[15:8] == MAGIC) && range_ok_c && csum_ok_c;
  assign idx_nxt_c = 4'(WORD_INDEX + 4'd1);

  // Error events; a coinciding FRAME_READ clears first so the event survives as 1
  assign bad_evt_c  = (state == S_CHECK) && !hdr_ok_c;
  assign ovr_evt_c  = FRAME_WRITE && (state != S_IDLE);
  assign bad_base_c = FRAME_READ ? 8'd0 : frames_bad;
  assign ovr_base_c = FRAME_READ ? 8'd0 : overrun;
  assign bad_next_c = (bad_evt_c && bad_base_c != 8'hFF) ? 8'(bad_base_c + 8'd1) : bad_base_c;
  assign ovr_next_c = (ovr_evt_c && ovr_base_c != 8'hFF) ? 8'(ovr_base_c + 8'd1) : ovr_base_c;

  // Snapshot uses pre-edge counter values
  assign status_c = {208'd0, overrun, frames_bad, frames_ok, 6'd0, state, 8'h5A};

  // Frame FSM, counters and status register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      buffer     <= '0;
      frames_ok  <= '0;
      frames_bad <= '0;
      overrun    <= '0;
      STATUS_OUT <= '0;
      WORD_OUT   <= '0;
      WORD_INDEX <= '0;
      WORD_VALID <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      frames_bad <= bad_next_c;
      overrun    <= ovr_next_c;
      if (FRAME_READ) begin
        STATUS_OUT <= status_c;
      end

      case (state)
        S_IDLE: begin
          if (FRAME_WRITE) begin
            buffer <= FRAME_IN;
            state  <= S_CHECK;
            BUSY   <= 1'b1;
          end
        end
        S_CHECK: begin
          if (hdr_ok_c) begin
            state      <= S_SEND;
            WORD_VALID <= 1'b1;
            WORD_INDEX <= 4'd1;
            WORD_OUT   <= buffer[31:16];
            frames_ok  <= 16'(frames_ok + 16'd1);
          end else begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end
        end
        S_SEND: begin
          // WORD_VALID is always high here, so READY alone marks the handshake
          if (WORD_READY) begin
            if (WORD_INDEX == n_c) begin
              WORD_VALID <= 1'b0;
              state      <= S_IDLE;
              BUSY       <= 1'b0;
            end else begin
              WORD_INDEX <= idx_nxt_c;
              WORD_OUT   <= buffer[{idx_nxt_c, 4'h0} +: WORD_W];
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          WORD_VALID <= 1'b0;
          BUSY       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_unpack.sv
// Testbench for spi_frame_unpack: scoreboard of expected (index, word) pairs
// filled when frames are written and drained by a monitor at each handshake,
// plus a counter model checked through status snapshots.
module tb_spi_frame_unpack;

`ifdef SPI_FRAME_CHECKSUM_EN
  localparam int NMAX = 14;
`else
  localparam int NMAX = 15;
`endif

  logic         CLK;
  logic         RESET;
  logic [255:0] FRAME_IN;
  logic         FRAME_WRITE;
  logic         FRAME_READ;
  logic [255:0] STATUS_OUT;
  logic [15:0]  WORD_OUT;
  logic [3:0]   WORD_INDEX;
  logic         WORD_VALID;
  logic         WORD_READY;
  logic         BUSY;

  spi_frame_unpack #(.MAGIC(8'hA5)) dut (
    .CLK(CLK), .RESET(RESET), .FRAME_IN(FRAME_IN), .FRAME_WRITE(FRAME_WRITE),
    .FRAME_READ(FRAME_READ), .STATUS_OUT(STATUS_OUT), .WORD_OUT(WORD_OUT),
    .WORD_INDEX(WORD_INDEX), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [19:0] sb[$];
  logic [15:0] ok_m  = '0;
  logic [7:0]  bad_m = '0;
  logic [7:0]  ovr_m = '0;
  bit          stalled = 1'b0;
  logic [19:0] held_val = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [255:0] make_frame(input logic [7:0] magic, input logic [3:0] n,
                                              input logic [15:0] seed);
    logic [255:0] f;
    logic [15:0]  x;
    f = '0;
    f[15:0] = {magic, n, 4'h0};
    for (int k = 1; k < 16; k++) f[16*k +: 16] = 16'(seed + 16'(k) * 16'h1111);
`ifdef SPI_FRAME_CHECKSUM_EN
    x = '0;
    for (int k = 0; k < 15; k++) x = x ^ f[16*k +: 16];
    f[255:240] = x;
`endif
    return f;
  endfunction

  function automatic bit frame_valid(input logic [255:0] f);
    bit ok;
    logic [15:0] x;
    ok = (f[15:8] == 8'hA5) && (f[7:4] != 4'd0) && (int'(f[7:4]) <= NMAX);
`ifdef SPI_FRAME_CHECKSUM_EN
    x = '0;
    for (int k = 0; k < 15; k++) x = x ^ f[16*k +: 16];
    if (x != f[255:240]) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Frame written while idle: predict words or a header error
  task automatic write_new(input logic [255:0] f);
    if (frame_valid(f)) begin
      for (int k = 1; k <= int'(f[7:4]); k++) sb.push_back({4'(k), f[16*k +: 16]});
      ok_m = 16'(ok_m + 16'd1);
    end else if (bad_m != 8'hFF) begin
      bad_m = 8'(bad_m + 8'd1);
    end
    FRAME_IN = f;
    FRAME_WRITE = 1'b1;
    tick();
    FRAME_WRITE = 1'b0;
  endtask

  // Frame written while busy: must be dropped
  task automatic write_drop(input logic [255:0] f);
    if (ovr_m != 8'hFF) ovr_m = 8'(ovr_m + 8'd1);
    FRAME_IN = f;
    FRAME_WRITE = 1'b1;
    tick();
    FRAME_WRITE = 1'b0;
  endtask

  task automatic read_status(input string tag, input logic [1:0] st);
    logic [255:0] exp;
    exp = {208'd0, ovr_m, bad_m, ok_m, 6'd0, st, 8'h5A};
    FRAME_READ = 1'b1;
    tick();
    FRAME_READ = 1'b0;
    check(tag, STATUS_OUT, exp);
    bad_m = '0;
    ovr_m = '0;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = !BUSY && (sb.size() == 0);
    end
    check(tag, done, 1'b1);
  endtask

  // Monitor: compare each accepted word and check stability while stalled
  always @(negedge CLK) begin
    if (!RESET && WORD_VALID) begin
      if (stalled) check("hold", {WORD_INDEX, WORD_OUT}, held_val);
      if (WORD_READY) begin
        if (sb.size() == 0) check("spurious_valid", WORD_VALID, 1'b0);
        else check("word", {WORD_INDEX, WORD_OUT}, sb.pop_front());
      end
      stalled  = !WORD_READY;
      held_val = {WORD_INDEX, WORD_OUT};
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] f;
    RESET = 1'b1; FRAME_IN = '0; FRAME_WRITE = 1'b0; FRAME_READ = 1'b0; WORD_READY = 1'b1;
    #3;
    check("rst_valid", WORD_VALID, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_word", WORD_OUT, 16'h0);
    check("rst_index", WORD_INDEX, 4'h0);
    check("rst_status", STATUS_OUT, 256'h0);
    tick(); tick();
    RESET = 1'b0;
    tick();

    // Basic 3-word frame, latency t+2
    write_new(make_frame(8'hA5, 4'd3, 16'h0));
    check("lat_check_valid", WORD_VALID, 1'b0);
    check("lat_check_busy", BUSY, 1'b1);
    tick();
    check("lat_valid", WORD_VALID, 1'b1);
    check("lat_first", {WORD_INDEX, WORD_OUT}, {4'd1, 16'h1111});
    wait_idle("drain_basic");
    read_status("status_basic", 2'd0);

    // Backpressure for 5 cycles on word 1
    WORD_READY = 1'b0;
    write_new(make_frame(8'hA5, 4'd3, 16'h0));
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("stall_index", WORD_INDEX, 4'd1);
    WORD_READY = 1'b1;
    wait_idle("drain_stall");

    // Bad magic: no words, error counter then cleared by read
    write_new(make_frame(8'h55, 4'd3, 16'h0));
    wait_idle("drain_badhdr");
    read_status("status_bad1", 2'd0);
    read_status("status_bad0", 2'd0);

    // Zero-length header is also invalid
    write_new(make_frame(8'hA5, 4'd0, 16'h0));
    wait_idle("drain_n0");

    // Overrun during a max-length frame leaves it intact
    WORD_READY = 1'b0;
    write_new(make_frame(8'hA5, 4'(NMAX), 16'h0123));
    write_drop(make_frame(8'hA5, 4'd2, 16'hBEEF));
    tick(); tick();
    WORD_READY = 1'b1;
    wait_idle("drain_ovr");
    read_status("status_ovr1", 2'd0);

    // Saturation at 255, then a coinciding read+overrun
    WORD_READY = 1'b0;
    write_new(make_frame(8'hA5, 4'd1, 16'h0400));
    tick();
    for (int i = 0; i < 300; i++) write_drop(make_frame(8'hA5, 4'd1, 16'(i)));
    FRAME_IN = make_frame(8'hA5, 4'd1, 16'h0);
    FRAME_WRITE = 1'b1;
    FRAME_READ = 1'b1;
    tick();
    FRAME_WRITE = 1'b0;
    FRAME_READ = 1'b0;
    check("status_sat", STATUS_OUT, {208'd0, 8'hFF, 8'd0, ok_m, 6'd0, 2'd2, 8'h5A});
    bad_m = '0;
    ovr_m = 8'd1;
    read_status("status_coincide", 2'd2);
    WORD_READY = 1'b1;
    wait_idle("drain_sat");

    // FRAME_WRITE on the final handshake is dropped
    write_new(make_frame(8'hA5, 4'd1, 16'h0700));
    tick();
    write_drop(make_frame(8'hA5, 4'd2, 16'h0800));
    check("final_drop_busy", BUSY, 1'b0);
    wait_idle("drain_final");
    read_status("status_final", 2'd0);

    // Asynchronous reset in the middle of SEND
    WORD_READY = 1'b0;
    write_new(make_frame(8'hA5, 4'(NMAX), 16'h0900));
    tick();
    #2 RESET = 1'b1;
    #1;
    check("arst_valid", WORD_VALID, 1'b0);
    check("arst_busy", BUSY, 1'b0);
    sb.delete();
    ok_m = '0; bad_m = '0; ovr_m = '0;
    tick();
    RESET = 1'b0;
    WORD_READY = 1'b1;
    tick();
    write_new(make_frame(8'hA5, 4'd1, 16'h0A00));
    wait_idle("drain_after_rst");
    read_status("status_after_rst", 2'd0);

`ifdef SPI_FRAME_CHECKSUM_EN
    // Checksum-protected frames
    write_new(make_frame(8'hA5, 4'd2, 16'h0B00));
    wait_idle("drain_cs_ok");
    f = make_frame(8'hA5, 4'd2, 16'h0B00);
    f[240] = ~f[240];
    write_new(f);
    wait_idle("drain_cs_bad");
    read_status("status_cs_bad", 2'd0);
    write_new(make_frame(8'hA5, 4'd15, 16'h0C00));
    wait_idle("drain_cs_n15");
    read_status("status_cs_n15", 2'd0);
`else
    // Word 15 is ordinary payload without the checksum option
    f = make_frame(8'hA5, 4'd15, 16'h0D00);
    f[255:240] = 16'hCAFE;
    write_new(f);
    wait_idle("drain_n15");
    read_status("status_n15", 2'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
